// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding the CPU rx_data/irr/ack interface.
// Two-flop synchroniser, start-bit glitch rejection, frame-error detection with
// break handling, and ack-edge consumption of received bytes.
// Optional feature: define UART_RX_FIFO_EN to replace the single holding
// register with a 4-entry circular FIFO.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       irr,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntBitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser and arming
  // ---------------------------------------------------------------------------
  logic       rx_meta_q;
  logic       rx_s_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       armed_d;

  // fill_q marks when rx_s_q carries a real line value rather than its reset
  // value, so a line held low through reset release cannot arm the receiver.
  assign armed_d = armed_q | (fill_q[1] & rx_s_q);

  // Two-flop synchroniser plus arming latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      fill_q    <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      fill_q    <= {fill_q[0], 1'b1};
      armed_q   <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            push;

  // Next-state logic: bit timing, sampling and byte push.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (armed_q && !rx_s_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalfEnd) begin
          if (!rx_s_q) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            // Start bit vanished by mid-bit: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntBitEnd) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntBitEnd) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        // Line held low after a bad stop bit: wait silently for idle.
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------
  // Ack edge detection and byte storage
  // ---------------------------------------------------------------------------
  logic ack_q;
  logic pop_ev;
  logic drop;
  logic overrun_q, overrun_d;

  assign pop_ev = ack & ~ack_q;

  // Pop clears overrun; a dropped byte sets it in the same cycle.
  assign overrun_d = (overrun_q & ~pop_ev) | drop;

  // Ack edge register and sticky overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ack_q     <= ack;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q, count_d;
  logic [2:0] count_after_pop;
  logic       eff_pop;
  logic       wr_en;

  // FIFO control: pop is applied before push so a full FIFO can accept a byte
  // in the same cycle it is acknowledged.
  always_comb begin
    eff_pop         = pop_ev & (count_q != 3'd0);
    count_after_pop = count_q - {2'b00, eff_pop};
    rd_ptr_d        = rd_ptr_q + {1'b0, eff_pop};
    wr_en           = 1'b0;
    drop            = 1'b0;
    if (push) begin
      if (count_after_pop == 3'd4) begin
        drop = 1'b1;
      end else begin
        wr_en = 1'b1;
      end
    end
    wr_ptr_d = wr_ptr_q + {1'b0, wr_en};
    count_d  = count_after_pop + {2'b00, wr_en};
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'h00;
      end
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign irr     = (count_q != 3'd0);
  assign rx_data = mem_q[rd_ptr_q];
`else
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic       full_after_pop;

  // Holding register: pop first, then accept the new byte if space remains.
  always_comb begin
    full_after_pop = full_q & ~pop_ev;
    hold_d         = hold_q;
    full_d         = full_after_pop;
    drop           = 1'b0;
    if (push) begin
      if (full_after_pop) begin
        drop = 1'b1;
      end else begin
        hold_d = shift_q;
        full_d = 1'b1;
      end
    end
  end

  // Holding register state; data is kept after the byte is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign irr     = full_q;
  assign rx_data = hold_q;
`endif

endmodule
